store_inst_dispatch: RTL and testbench

Parametrised successor to the store-instruction decoder. Buffers incoming store-queue instructions in a small FIFO and decodes each one as store, sync or illegal. Each instruction waits on the pop_prev dependency token from the compute stage, is issued to the store engine over a valid/ready handshake, and the push_prev token is returned on completion. Sits between the fetch stage's store queue and the store engine.

---
 rtl/store_dispatch_pkg.sv | 42 ++++
 rtl/inst_fifo.sv | 52 +++++
 rtl/store_inst_dispatch.sv | 149 ++++++++++++++
 tb/tb_store_inst_dispatch.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// store_dispatch_pkg : shared FSM type, default field layout and decode helper
// Rev 1.0
// ============================================================================
package store_dispatch_pkg;

    localparam int unsigned c_inst_w        = 128;
    localparam int unsigned c_op_w          = 3;
    localparam int unsigned c_op_store      = 1;
    localparam int unsigned c_pop_prev_bit  = 3;
    localparam int unsigned c_push_prev_bit = 5;
    localparam int unsigned c_xsize_lsb     = 80;
    localparam int unsigned c_xsize_w       = 16;
    localparam int unsigned c_depth         = 4;
    localparam int unsigned c_tok_w         = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_BUSY  = 3'd3,
        S_PUSH  = 3'd4
    } state_t;

    typedef struct packed {
        logic is_store;
        logic is_sync;
        logic illegal;
    } decode_t;

    // A store opcode with zero transfer size is a pure token synchronisation.
    function automatic decode_t decode(input logic is_op, input logic xsize_nz);
        decode_t d;
        d.is_store = is_op & xsize_nz;
        d.is_sync  = is_op & ~xsize_nz;
        d.illegal  = ~is_op;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
// inst_fifo : DEPTH x WIDTH synchronous FIFO, wrap-bit pointers, async reset
// Rev 1.0
// ============================================================================
module inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_ptr_one = 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wptr;
    logic [c_addr_w:0] r_rptr;
    logic              w_wr;
    logic              w_rd;

    // Same index with opposite wrap bits means the write side lapped the read side.
    assign o_full  = (r_wptr[c_addr_w] != r_rptr[c_addr_w]) &&
                     (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]);
    assign o_empty = (r_wptr == r_rptr);
    assign w_wr    = i_wr_en & ~o_full;
    assign w_rd    = i_rd_en & ~o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + c_ptr_one;
            if (w_rd) r_rptr <= r_rptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[c_addr_w-1:0]] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rptr[c_addr_w-1:0]];

endmodule
`default_nettype wire

// File: rtl/store_inst_dispatch.sv
`default_nettype none
// ============================================================================
// store_inst_dispatch : buffers store-queue instructions, resolves the compute
// dependency token, issues stores to the engine and returns completion tokens
// Rev 1.0
// ============================================================================
module store_inst_dispatch
    import store_dispatch_pkg::*;
#(
    parameter int unsigned INST_W        = c_inst_w,
    parameter int unsigned OP_W          = c_op_w,
    parameter int unsigned OP_STORE      = c_op_store,
    parameter int unsigned POP_PREV_BIT  = c_pop_prev_bit,
    parameter int unsigned PUSH_PREV_BIT = c_push_prev_bit,
    parameter int unsigned XSIZE_LSB     = c_xsize_lsb,
    parameter int unsigned XSIZE_W       = c_xsize_w,
    parameter int unsigned DEPTH         = c_depth,
    parameter int unsigned TOK_W         = c_tok_w
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [INST_W-1:0] inst_data,
    input  logic              tok_in,
    output logic              tok_out,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [INST_W-1:0] st_inst,
    input  logic              st_done,
    output logic [TOK_W-1:0]  tok_count,
    output logic              idle,
    output logic              err_illegal,
    output logic              err_tok_ovf
);
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic [INST_W-1:0]  w_head;
    logic [OP_W-1:0]    w_op;
    logic [XSIZE_W-1:0] w_xsize;
    decode_t            w_dec;
    logic               w_pop_prev;
    logic               w_push_prev;
    logic               w_tok_avail;
    logic               w_tok_ok;
    logic               w_consume;

    state_t             r_state;
    logic               r_st_valid;
    logic               r_tok_out;
    logic               r_err_illegal;
    logic               r_err_tok_ovf;
    logic [TOK_W-1:0]   r_tok_count;

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_inst_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .i_wr_en   (inst_valid),
        .i_wr_data (inst_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign w_op        = w_head[OP_W-1:0];
    assign w_xsize     = w_head[XSIZE_LSB +: XSIZE_W];
    assign w_dec       = decode(w_op == OP_W'(OP_STORE), |w_xsize);
    assign w_pop_prev  = w_head[POP_PREV_BIT];
    assign w_push_prev = w_head[PUSH_PREV_BIT];

    // A token arriving this very cycle can be spent immediately.
    assign w_tok_avail = (r_tok_count != '0) | tok_in;
    assign w_tok_ok    = ~w_pop_prev | w_tok_avail;
    assign w_consume   = (r_state == S_WAIT) & w_pop_prev & w_tok_avail;
    assign w_pop       = ((r_state == S_IDLE) & ~w_fifo_empty & w_dec.illegal) |
                         (r_state == S_PUSH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_st_valid    <= 1'b0;
            r_tok_out     <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            r_tok_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        if (w_dec.illegal) r_err_illegal <= 1'b1;
                        else               r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_tok_ok) begin
                        if (w_dec.is_sync) begin
                            r_state   <= S_PUSH;
                            r_tok_out <= w_push_prev;
                        end else if (w_dec.is_store) begin
                            r_state    <= S_ISSUE;
                            r_st_valid <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (st_ready) begin
                        r_state    <= S_BUSY;
                        r_st_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (st_done) begin
                        r_state   <= S_PUSH;
                        r_tok_out <= w_push_prev;
                    end
                end
                S_PUSH:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tok_count   <= '0;
            r_err_tok_ovf <= 1'b0;
        end else if (tok_in && !w_consume) begin
            if (&r_tok_count) r_err_tok_ovf <= 1'b1;
            else              r_tok_count   <= r_tok_count + TOK_W'(1);
        end else if (w_consume && !tok_in) begin
            r_tok_count <= r_tok_count - TOK_W'(1);
        end
    end

    assign inst_ready  = ~w_fifo_full;
    assign tok_out     = r_tok_out;
    assign st_valid    = r_st_valid;
    assign st_inst     = r_st_valid ? w_head : '0;
    assign tok_count   = r_tok_count;
    assign idle        = w_fifo_empty & (r_state == S_IDLE);
    assign err_illegal = r_err_illegal;
    assign err_tok_ovf = r_err_tok_ovf;

endmodule
`default_nettype wire

// File: tb/tb_store_inst_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_store_inst_dispatch : directed scenarios plus randomized traffic against
// an in-order transaction scoreboard
// Rev 1.0
// ============================================================================
module tb_store_inst_dispatch;
    localparam int unsigned INST_W = 128;
    localparam int unsigned TOK_W  = 8;
    localparam int          N_RAND = 60;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              inst_valid = 1'b0;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data = '0;
    logic              tok_in = 1'b0;
    logic              tok_out;
    logic              st_valid;
    logic              st_ready = 1'b0;
    logic [INST_W-1:0] st_inst;
    logic              st_done = 1'b0;
    logic [TOK_W-1:0]  tok_count;
    logic              idle;
    logic              err_illegal;
    logic              err_tok_ovf;

    always #5 clock = ~clock;

    store_inst_dispatch #(
        .INST_W(128), .OP_W(3), .OP_STORE(1), .POP_PREV_BIT(3), .PUSH_PREV_BIT(5),
        .XSIZE_LSB(80), .XSIZE_W(16), .DEPTH(4), .TOK_W(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .tok_in(tok_in), .tok_out(tok_out), .st_valid(st_valid),
        .st_ready(st_ready), .st_inst(st_inst), .st_done(st_done), .tok_count(tok_count),
        .idle(idle), .err_illegal(err_illegal), .err_tok_ovf(err_tok_ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] mk_inst(input int op, input int xs, input bit pop, input bit push);
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        d[2:0]   = op[2:0];
        d[3]     = pop;
        d[5]     = push;
        d[95:80] = xs[15:0];
        return d;
    endfunction

    function automatic bit is_sync(input logic [127:0] d);
        return (d[2:0] == 3'd1) && (d[95:80] == 16'd0);
    endfunction

    function automatic bit is_illegal(input logic [127:0] d);
        return d[2:0] != 3'd1;
    endfunction

    task automatic write_one(input logic [127:0] d);
        inst_valid = 1'b1;
        inst_data  = d;
        tick();
        inst_valid = 1'b0;
    endtask

    // Cycle k=1 is the cycle sampled right after the call starts.
    task automatic watch(input int n, output int pulses, output int first, output bit saw_sv);
        pulses = 0; first = 0; saw_sv = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (tok_out) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (st_valid) saw_sv = 1'b1;
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_inst_ready"}, inst_ready, 1);
        check({pfx, "_idle"}, idle, 1);
        check({pfx, "_st_valid"}, st_valid, 0);
        check({pfx, "_tok_out"}, tok_out, 0);
        check({pfx, "_st_inst"}, st_inst, 0);
        check({pfx, "_tok_count"}, tok_count, 0);
        check({pfx, "_err_illegal"}, err_illegal, 0);
        check({pfx, "_err_tok_ovf"}, err_tok_ovf, 0);
    endtask

    typedef struct {
        logic [127:0] d;
        bit           issued;
    } ent_t;
    ent_t q[$];

    // Completions that produce no tok_out are only observable by what follows them.
    task automatic drop_silent();
        while (q.size() > 0 && !q[0].d[5] && (q[0].issued || is_sync(q[0].d)))
            void'(q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           pulses, first, acc_cyc, first_push, got_n, eng, cyc;
        int           sent, tokens, consumes, pushes_exp, illegal_n, rpulses;
        bit           saw_sv, acc, hs, done_pend, prev_hold;
        logic [127:0] d, prev_inst;
        logic [127:0] fill [5];
        logic [127:0] got  [5];
        ent_t         e;

        repeat (3) tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick();

        // Sync without dependency
        write_one(mk_inst(1, 0, 0, 1));
        watch(10, pulses, first, saw_sv);
        check("sync_pulses", pulses, 1);
        check("sync_latency", first, 3);
        check("sync_no_st_valid", saw_sv, 0);
        check("sync_idle", idle, 1);

        // Store waiting on a dependency token
        d = mk_inst(1, 16, 1, 0);
        write_one(d);
        repeat (6) tick();
        check("dep_blocked", st_valid, 0);
        check("dep_count0", tok_count, 0);
        tok_in = 1'b1;
        tick();
        tok_in = 1'b0;
        check("dep_st_valid", st_valid, 1);
        check("dep_count_coincide", tok_count, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dep_hold_valid", st_valid, 1);
            check("dep_hold_inst", st_inst, d);
        end
        st_ready = 1'b1;
        tick();
        st_ready = 1'b0;
        check("dep_hs_drop", st_valid, 0);
        st_done = 1'b1;
        tick();
        st_done = 1'b0;
        watch(4, pulses, first, saw_sv);
        check("dep_no_tok_out", pulses, 0);
        check("dep_idle", idle, 1);
        check("dep_count_end", tok_count, 0);

        // Illegal opcode followed by a sync
        inst_valid = 1'b1;
        inst_data  = mk_inst(3, 0, 0, 1);
        tick();
        inst_data  = mk_inst(1, 0, 0, 1);
        tick();
        inst_valid = 1'b0;
        watch(12, pulses, first, saw_sv);
        check("ill_err", err_illegal, 1);
        check("ill_sync_pulse", pulses, 1);
        check("ill_no_st_valid", saw_sv, 0);
        repeat (3) tick();
        check("ill_sticky", err_illegal, 1);

        // Fill the FIFO with the engine stalled
        for (int i = 0; i < 5; i++) fill[i] = mk_inst(1, 16 + i, 0, 1);
        st_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inst_valid = 1'b1;
            inst_data  = fill[i];
            tick();
        end
        check("fill_full", inst_ready, 0);
        inst_data = fill[4];
        tick();
        check("fill_5th_blocked", inst_ready, 0);
        got_n = 0; pulses = 0; first_push = -1; acc_cyc = -1; done_pend = 1'b0;
        st_ready = 1'b1;
        for (int c = 0; c < 200 && !(got_n == 5 && pulses == 5 && idle); c++) begin
            st_done   = done_pend;
            done_pend = 1'b0;
            if (tok_out) begin
                pulses++;
                if (first_push < 0) first_push = c;
            end
            acc = inst_valid && inst_ready;
            if (acc) acc_cyc = c;
            hs = st_valid && st_ready;
            if (hs) begin
                if (got_n < 5) got[got_n] = st_inst;
                got_n++;
            end
            tick();
            if (acc) inst_valid = 1'b0;
            if (hs) done_pend = 1'b1;
        end
        st_ready = 1'b0;
        st_done  = 1'b0;
        check("fill_issue_count", got_n, 5);
        for (int i = 0; i < 5; i++) check($sformatf("fill_order%0d", i), got[i], fill[i]);
        check("fill_pulses", pulses, 5);
        check("fill_5th_after_pop", (first_push >= 0) && (acc_cyc > first_push), 1);
        check("fill_idle", idle, 1);

        // Token counter saturation and consume interactions
        tok_in = 1'b1;
        repeat (255) tick();
        tok_in = 1'b0;
        check("sat_count255", tok_count, 255);
        check("sat_no_ovf_yet", err_tok_ovf, 0);
        tok_in = 1'b1;
        tick();
        tok_in = 1'b0;
        check("sat_hold", tok_count, 255);
        check("sat_ovf", err_tok_ovf, 1);
        write_one(mk_inst(1, 0, 1, 0));
        repeat (4) tick();
        check("sat_consume", tok_count, 254);
        inst_valid = 1'b1;
        inst_data  = mk_inst(1, 0, 1, 0);
        tick();
        inst_valid = 1'b0;
        tick();
        tok_in = 1'b1;
        tick();
        tok_in = 1'b0;
        check("sat_coincide", tok_count, 254);
        repeat (3) tick();
        check("sat_idle", idle, 1);
        check("sat_ovf_sticky", err_tok_ovf, 1);

        // Reset while the engine is busy
        write_one(mk_inst(1, 8, 0, 1));
        st_ready = 1'b1;
        repeat (3) tick();
        st_ready = 1'b0;
        write_one(mk_inst(1, 0, 0, 1));
        check("abort_in_busy", st_valid, 0);
        check("abort_not_idle", idle, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        watch(3, pulses, first, saw_sv);
        reset_n = 1'b1;
        check("abort_no_pulse_in_rst", pulses, 0);
        watch(6, pulses, first, saw_sv);
        check("abort_no_pulse_after", pulses, 0);
        check("abort_no_st_valid", saw_sv, 0);
        check("abort_idle", idle, 1);

        // Randomized traffic against the in-order scoreboard
        sent = 0; tokens = 0; consumes = 0; pushes_exp = 0; illegal_n = 0; rpulses = 0;
        eng = -1; cyc = 0; prev_hold = 1'b0; prev_inst = '0;
        q.delete();
        while (1) begin
            if (cyc > 6000) begin
                check("rand_timeout", 0, 1);
                break;
            end
            if (sent == N_RAND && !inst_valid && eng < 0 && idle && !st_valid) break;
            if (!inst_valid && sent < N_RAND && $urandom_range(0, 2) == 0) begin
                int o;
                o = $urandom_range(0, 4) == 0 ? $urandom_range(0, 6) : 1;
                if (o != 1) o = (o == 0) ? 0 : o + 1;
                inst_valid = 1'b1;
                inst_data  = mk_inst(o, $urandom_range(0, 1) == 1 ? 0 : $urandom_range(1, 65535),
                                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            st_ready = 1'($urandom_range(0, 1));
            tok_in   = (tokens < 200) && ($urandom_range(0, 2) == 0);
            st_done  = 1'b0;
            if (eng == 0) begin
                st_done = 1'b1;
                eng = -1;
            end else if (eng > 0) begin
                eng--;
            end

            if (tok_in) tokens++;
            if (prev_hold) begin
                check("rand_hold_valid", st_valid, 1);
                check("rand_hold_inst", st_inst, prev_inst);
            end
            if (tok_out) begin
                rpulses++;
                drop_silent();
                if (q.size() == 0) check("rand_tok_out_unexpected", 1, 0);
                else begin
                    check("rand_tok_out_src", {q[0].issued | is_sync(q[0].d), q[0].d[5]}, 2'b11);
                    void'(q.pop_front());
                end
            end
            if (st_valid && st_ready) begin
                drop_silent();
                if (q.size() == 0) check("rand_st_unexpected", 1, 0);
                else begin
                    check("rand_st_order", st_inst, q[0].d);
                    check("rand_st_fresh", q[0].issued, 0);
                    q[0].issued = 1'b1;
                end
                eng = $urandom_range(0, 3);
            end
            prev_hold = st_valid && !st_ready;
            prev_inst = st_inst;
            acc = inst_valid && inst_ready;
            if (acc) begin
                sent++;
                if (is_illegal(inst_data)) illegal_n++;
                else begin
                    e.d = inst_data;
                    e.issued = 1'b0;
                    q.push_back(e);
                    consumes   += int'(inst_data[3]);
                    pushes_exp += int'(inst_data[5]);
                end
            end
            tick();
            cyc++;
            if (acc) inst_valid = 1'b0;
        end
        tok_in   = 1'b0;
        st_ready = 1'b0;
        st_done  = 1'b0;
        check("rand_sent", sent, N_RAND);
        check("rand_tok_count", tok_count, tokens - consumes);
        check("rand_pulses", rpulses, pushes_exp);
        check("rand_err_illegal", err_illegal, illegal_n > 0);
        check("rand_err_ovf", err_tok_ovf, 0);
        drop_silent();
        check("rand_leftover", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
